// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard and stall sequencer for the 5-stage RV32 core.
//   Inputs : clk, reset (async, active-low), Decode/Execute source indices,
//            E/M/W destination indices, PCSrcE, ResultSrcb0E, RegWriteM/W,
//            MemReqM/MemReadyM handshake from the variable-latency data memory.
//   Outputs: ForwardAE/BE operand selects (10 = ALUResultM, 01 = ResultW),
//            Stall*/Flush* pipeline register controls, MemWait (FSM in WAIT),
//            sticky MemErr timeout flag and saturating StallCount.
module hazard_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             PCSrcE,
  input  logic             ResultSrcb0E,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemWait,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  state_t state_d, state_q;
  logic [15:0] wcnt_d, wcnt_q;
  logic err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic lw_stall, mem_stall;
  always_comb begin
    lw_stall  = ResultSrcb0E && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
    mem_stall = MemReqM && !MemReadyM;
    // M has priority over W; everything is quiet while reset is held low
    ForwardAE = !reset ? 2'b00
              : (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10
              : (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = !reset ? 2'b00
              : (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10
              : (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    // W is held rather than bubbled so the W forwarding source survives a memory wait
    StallE = reset && mem_stall;
    StallM = StallE;
    StallW = StallE;
    StallF = reset && (mem_stall || lw_stall);
    StallD = StallF;
    // a branch/load-use seen during a memory wait stays frozen in E and acts on release
    FlushD = reset && PCSrcE && !mem_stall;
    FlushE = reset && (PCSrcE || lw_stall) && !mem_stall;
    state_d = mem_stall ? S_WAIT : S_RUN;
    wcnt_d  = !mem_stall ? 16'd0
            : (state_q == S_RUN) ? 16'd1
            : (wcnt_q == TMO) ? wcnt_q : wcnt_q + 16'd1;
    err_d   = err_q || (mem_stall && wcnt_d == TMO);
    cnt_d   = (StallF && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign MemWait    = state_q == S_WAIT;
  assign MemErr     = err_q;
  assign StallCount = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic PCSrcE, ResultSrcb0E, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemWait, MemErr;
  logic [3:0] StallCount;
  logic [6:0] ctl;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

  hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .PCSrcE(PCSrcE), .ResultSrcb0E(ResultSrcb0E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .MemWait(MemWait), .MemErr(MemErr), .StallCount(StallCount)
  );

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {PCSrcE, ResultSrcb0E, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    PCSrcE = 1'b1; MemReqM = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    ResultSrcb0E = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    step(); step();
    n_cmp++; if (ctl !== 7'b0) begin n_bad++; $display("FAIL reset_ctl: got %b exp 0000000", ctl); end
    n_cmp++; if (ForwardAE !== 2'b00) begin n_bad++; $display("FAIL reset_fwd: got %b exp 00", ForwardAE); end
    n_cmp++; if ({MemWait, MemErr, StallCount} !== 6'b0) begin n_bad++; $display("FAIL reset_regs: got %b exp 000000", {MemWait, MemErr, StallCount}); end
    idle();
    #2 reset = 1'b1;
    step();
    n_cmp++; if (StallCount !== 4'd0) begin n_bad++; $display("FAIL reset_cnt_idle: got %0d exp 0", StallCount); end
  endtask

  task automatic test_forward();
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b1000) begin n_bad++; $display("FAIL fwd_m_prio: got %b exp 1000", {ForwardAE, ForwardBE}); end
    RegWriteM = 1'b0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin n_bad++; $display("FAIL fwd_w: got %b exp 0100", {ForwardAE, ForwardBE}); end
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_bad++; $display("FAIL fwd_x0: got %b exp 0000", {ForwardAE, ForwardBE}); end
    RdM = 5'd9; RdW = 5'd12; Rs1E = 5'd12; Rs2E = 5'd9;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin n_bad++; $display("FAIL fwd_split: got %b exp 0110", {ForwardAE, ForwardBE}); end
    RegWriteW = 1'b0;
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 4'b0010) begin n_bad++; $display("FAIL fwd_w_off: got %b exp 0010", {ForwardAE, ForwardBE}); end
    n_cmp++; if (ctl !== 7'b0) begin n_bad++; $display("FAIL fwd_no_stall: got %b exp 0000000", ctl); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    ResultSrcb0E = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    n_cmp++; if (ctl !== 7'b1100001) begin n_bad++; $display("FAIL lw_ctl: got %b exp 1100001", ctl); end
    step();
    exp_cnt = 1;
    idle();
    n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL lw_cnt: got %0d exp %0d", StallCount, exp_cnt); end
    ResultSrcb0E = 1'b1; RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
    #1;
    n_cmp++; if (ctl !== 7'b0) begin n_bad++; $display("FAIL lw_x0_ctl: got %b exp 0000000", ctl); end
    step();
    idle();
    n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL lw_x0_cnt: got %0d exp %0d", StallCount, exp_cnt); end
  endtask

  task automatic test_branch();
    PCSrcE = 1'b1;
    #1;
    n_cmp++; if (ctl !== 7'b0000011) begin n_bad++; $display("FAIL br_ctl: got %b exp 0000011", ctl); end
    step();
    idle();
    n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL br_cnt: got %0d exp %0d", StallCount, exp_cnt); end
  endtask

  task automatic test_mem_wait();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    #1;
    n_cmp++; if (ctl !== 7'b1111100) begin n_bad++; $display("FAIL mw_c1_ctl: got %b exp 1111100", ctl); end
    n_cmp++; if (MemWait !== 1'b0) begin n_bad++; $display("FAIL mw_c1_wait: got %b exp 0", MemWait); end
    for (int c = 2; c <= 3; c++) begin
      step();
      n_cmp++; if (ctl !== 7'b1111100) begin n_bad++; $display("FAIL mw_c%0d_ctl: got %b exp 1111100", c, ctl); end
      n_cmp++; if (MemWait !== 1'b1) begin n_bad++; $display("FAIL mw_c%0d_wait: got %b exp 1", c, MemWait); end
    end
    step();
    n_cmp++; if (MemWait !== 1'b1) begin n_bad++; $display("FAIL mw_c4_wait: got %b exp 1", MemWait); end
    MemReadyM = 1'b1;
    #1;
    n_cmp++; if (ctl !== 7'b0000011) begin n_bad++; $display("FAIL mw_release_ctl: got %b exp 0000011", ctl); end
    step();
    idle();
    exp_cnt += 3;
    n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL mw_cnt: got %0d exp %0d", StallCount, exp_cnt); end
    n_cmp++; if ({MemWait, MemErr} !== 2'b00) begin n_bad++; $display("FAIL mw_after: got %b exp 00", {MemWait, MemErr}); end
  endtask

  task automatic test_timeout();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    step(); step(); step();
    n_cmp++; if (MemErr !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b exp 0", MemErr); end
    step();
    exp_cnt += 4;
    n_cmp++; if (MemErr !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b exp 1", MemErr); end
    n_cmp++; if (StallF !== 1'b1) begin n_bad++; $display("FAIL to_still_stall: got %b exp 1", StallF); end
    MemReadyM = 1'b1;
    step();
    n_cmp++; if ({MemErr, MemWait} !== 2'b10) begin n_bad++; $display("FAIL to_sticky: got %b exp 10", {MemErr, MemWait}); end
    n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL to_cnt: got %0d exp %0d", StallCount, exp_cnt); end
    MemReadyM = 1'b0;
    step(); step();
    n_cmp++; if (MemWait !== 1'b1) begin n_bad++; $display("FAIL to_rewait: got %b exp 1", MemWait); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({MemErr, MemWait, StallCount} !== 6'b0) begin n_bad++; $display("FAIL to_reset_regs: got %b exp 000000", {MemErr, MemWait, StallCount}); end
    n_cmp++; if (ctl !== 7'b0) begin n_bad++; $display("FAIL to_reset_ctl: got %b exp 0000000", ctl); end
    idle();
    step();
    reset = 1'b1;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_saturation();
    ResultSrcb0E = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_cnt = (i < 15) ? i : 15;
      n_cmp++; if (StallCount !== 4'(exp_cnt)) begin n_bad++; $display("FAIL sat_%0d: got %0d exp %0d", i, StallCount, exp_cnt); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
